// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshaked single-port memory between the
// instruction-fetch port and the load/store port. Data accesses win, except
// that a saturating streak counter hands the memory to fetch after
// STREAK_MAX back-to-back data grants while fetch was waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                d_valid_q,   d_valid_d;
    logic                d_grant;
    logic                if_grant;

    // Next-state and next-output logic: arbitrate in IDLE, wait for the memory in BUSY, pulse valid in RESP
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        d_grant     = 1'b0;
        if_grant    = 1'b0;

        case (state_q)
            IDLE: begin
                d_grant  = d_req && (!if_req || (streak_q < STREAK_LIM));
                if_grant = !d_grant && if_req;
                if (d_grant) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    owner_d     = OWN_D;
                    state_d     = BUSY;
                    // Count only data grants that made fetch wait
                    if (if_req && (streak_q < STREAK_LIM)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (if_grant) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    owner_d    = OWN_IF;
                    streak_d   = '0;
                    state_d    = BUSY;
                end
                if (!if_req) begin
                    streak_d = '0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = RESP;
                    if (owner_q == OWN_D) begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;

    // Stalls follow the live request so the pipeline releases in the valid cycle
    assign if_stall = if_req & ~if_valid_q;
    assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, handshaked memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage RISC_V core.
- Data requests have priority. A streak counter stops instruction fetch from starving.
- Produces per-requester stall signals that feed the PC/IF_ID write enables and the pipe-register enables.

Parameters:
ADDR_W, 10, word-address width (PC[11:2] / ALU_OUT[11:2])
DATA_W, 32, data width
STREAK_MAX, 4, max consecutive data grants while IF is waiting (range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
if_req  input  1  fetch request; held with if_addr until if_valid
if_addr  input  ADDR_W  fetch word address
if_rdata  output  DATA_W  fetched instruction, valid with if_valid
if_valid  output  1  one-cycle completion pulse for IF
if_stall  output  1  if_req & ~if_valid
d_req  input  1  data request; d_we/d_addr/d_wdata held until d_valid
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data word address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data, valid with d_valid
d_valid  output  1  one-cycle completion pulse for MEM
d_stall  output  1  d_req & ~d_valid
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory done this cycle (may be the same cycle as the first mem_req)
mem_rdata  input  DATA_W  read data, sampled when mem_ready=1

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: state=IDLE; mem_req, mem_we, if_valid, d_valid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; streak=0; owner=IF.
- Outputs: all registered except if_stall and d_stall, which are combinational from req and the registered valid.
- FSM states:
  - IDLE: arbitrate.
    - Data grant when d_req=1 and (if_req=0 or streak<STREAK_MAX).
    - Otherwise IF grant when if_req=1.
    - On a grant: latch addr / we / wdata into the mem_* registers, set mem_req=1, record the owner, go to BUSY.
    - Data grant: mem_we=d_we, mem_wdata=d_wdata. IF grant: mem_we=0.
    - No request: stay in IDLE.
  - BUSY: mem_req and all mem_* outputs held stable.
    - On mem_ready=1: clear mem_req and mem_we next cycle, go to RESP.
    - Read (IF, or data with we=0): mem_rdata is captured into the owner's rdata register.
    - Store: d_rdata is unchanged.
  - RESP: owner's valid=1 for exactly this cycle, then go to IDLE. A new grant is possible only from IDLE (one turnaround cycle).
- Latency: for a request seen in IDLE at cycle t with zero-wait memory (mem_ready=1 at t+1), mem_req=1 at t+1 and valid=1 at t+2. Each memory wait state adds one cycle.
- Streak counter (4-bit):
  - +1 on each data grant while if_req=1, saturating at STREAK_MAX.
  - Cleared on an IF grant, or on any IDLE cycle with if_req=0.
- Boundary conditions:
  - Simultaneous if_req and d_req with streak<STREAK_MAX: data wins.
  - Simultaneous requests with streak==STREAK_MAX: IF wins.
  - mem_ready while in IDLE or RESP: ignored.
  - Requester drops req during BUSY (e.g. IF flush on PCSrc): access still completes and valid still pulses; the requester discards it. No abort.
  - reset mid-access: state returns to IDLE next edge, mem_req=0, the access is abandoned, and no valid is produced. The memory tolerates mem_req dropping without mem_ready.
  - Address and data are taken from the latched registers, so requester changes during BUSY do not affect the memory.
  - mem_addr wraps naturally at 2^ADDR_W; no range check.

Test Plan:
- IF only: if_req=1, if_addr=0x004, memory returns 0x00500093 with zero wait → mem_req at t+1 with mem_addr=0x004, mem_we=0; if_valid=1 and if_rdata=0x00500093 at t+2; if_stall=1 at t and t+1, 0 at t+2.
- Store then load, mem_ready delayed 2 cycles: d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF; mem_we=1 held 3 cycles; d_valid at grant+4; d_rdata unchanged. Then a load from 0x010 returns 0xDEADBEEF.
- Contention, STREAK_MAX=4: if_req and d_req held high continuously → grant order D,D,D,D,I,D,D,D,D,I; streak never exceeds 4.
- Simultaneous single requests with streak=0 → data granted first, IF granted in the IDLE cycle after d_valid.
- Reset asserted in BUSY → next cycle mem_req=0, state IDLE, no if_valid/d_valid. mem_ready=1 arriving afterwards in IDLE is ignored and produces no valid.
- Flush: if_req drops mid-BUSY → if_valid still pulses once; a following d_req is granted normally.
